// File: rtl/flaf_output_mac_if.sv
// FLAF output MAC bus: start/busy control, weight-bank read port,
// and the filter output toward the error stage.
interface flaf_output_mac_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic              busy;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;
  logic [WIDTH-1:0]  x_data;
  logic [WIDTH-1:0]  y_out;
  logic              y_valid;

  modport master (
    input  start, w_data, x_data,
    output busy, w_rd_en, w_addr, y_out, y_valid
  );

  modport slave (
    output start, w_data, x_data,
    input  busy, w_rd_en, w_addr, y_out, y_valid
  );
endinterface

// File: rtl/flaf_output_mac.sv
// FLAF weight-bank read side: y = sat(sum w[k]*x[k]) in signed
// fixed point, one sample per start request.
module flaf_output_mac #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 12,
  parameter int NTAPS  = 8,
  parameter int ADDR_W = 3
) (
  input logic                clk,
  input logic                reset,
  flaf_output_mac_if.master  bus
);
  localparam int ACC_W = 2*WIDTH - FRAC + $clog2(NTAPS);
  localparam int PW    = 2*WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS-1);

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [1:0]              state;
  logic                    drain_d;
  logic                    rd_d;
  logic                    prod_v;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    prod_sh;
  logic signed [ACC_W-1:0] acc;
  logic [WIDTH-1:0]        y_sat;

  // Floor toward -inf; the shifted product always fits the accumulator.
  assign prod_sh = prod >>> FRAC;

  always_comb begin
    y_sat = acc[WIDTH-1:0];
    if (acc > MAXV)
      y_sat = MAXV[WIDTH-1:0];
    else if (acc < MINV)
      y_sat = MINV[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      drain_d     <= 1'b0;
      rd_d        <= 1'b0;
      prod_v      <= 1'b0;
      prod        <= '0;
      acc         <= '0;
      bus.busy    <= 1'b0;
      bus.w_rd_en <= 1'b0;
      bus.w_addr  <= '0;
      bus.y_out   <= '0;
      bus.y_valid <= 1'b0;
    end else begin
      bus.y_valid <= 1'b0;
      rd_d        <= bus.w_rd_en;
      prod_v      <= rd_d;
      if (rd_d)
        prod <= $signed(bus.w_data) * $signed(bus.x_data);
      if (prod_v)
        acc <= acc + $signed(prod_sh[ACC_W-1:0]);
      unique case (state)
        IDLE: begin
          bus.busy <= bus.start;
          if (bus.start) begin
            state       <= RUN;
            bus.w_rd_en <= 1'b1;
            bus.w_addr  <= '0;
            acc         <= '0;
          end
        end
        RUN: begin
          if (bus.w_addr == LAST) begin
            bus.w_rd_en <= 1'b0;
            drain_d     <= 1'b0;
            state       <= DRAIN;
          end else begin
            bus.w_addr <= bus.w_addr + 1'b1;
          end
        end
        // Two cycles: last read data arrives, then its product lands.
        DRAIN: begin
          if (drain_d)
            state <= OUT;
          else
            drain_d <= 1'b1;
        end
        OUT: begin
          bus.y_out   <= y_sat;
          bus.y_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flaf_output_mac.sv
// Randomized bench for flaf_output_mac against a plain-arithmetic
// model of the filter sum with 1-cycle-latency weight/input banks.
module tb_flaf_output_mac;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] w_mem [8];
  logic [15:0] x_mem [8];
  logic [2:0]  addr_q [$];

  always #5 clk = ~clk;

  flaf_output_mac_if #(.WIDTH(16), .ADDR_W(3)) bus ();

  flaf_output_mac #(
    .WIDTH(16), .FRAC(12), .NTAPS(8), .ADDR_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always @(posedge clk) begin
    if (bus.w_rd_en) begin
      bus.w_data <= w_mem[bus.w_addr];
      bus.x_data <= x_mem[bus.w_addr];
    end else begin
      bus.w_data <= 16'($urandom);
      bus.x_data <= 16'($urandom);
    end
  end

  always @(negedge clk)
    if (bus.w_rd_en) addr_q.push_back(bus.w_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_y();
    longint s;
    s = 0;
    for (int k = 0; k < 8; k++)
      s += (longint'($signed(w_mem[k])) *
            longint'($signed(x_mem[k]))) >>> 12;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  task automatic fill(input logic [15:0] w, input logic [15:0] x);
    for (int k = 0; k < 8; k++) begin
      w_mem[k] = w;
      x_mem[k] = x;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 30 && !bus.y_valid) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_one(input string tag);
    logic [15:0] exp;
    int lat;
    bit ok;
    exp = ref_y();
    addr_q.delete();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 32'd11);
    chk({tag, "_y"}, {16'b0, bus.y_out}, {16'b0, exp});
    ok = (addr_q.size() == 8);
    for (int i = 0; i < addr_q.size(); i++)
      if (addr_q[i] != 3'(i)) ok = 1'b0;
    chk({tag, "_addr"}, {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {30'b0, bus.busy, bus.y_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] exp;
    bus.start = 1'b0;
    fill(16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_low", {bus.busy, bus.w_rd_en, bus.w_addr, bus.y_valid,
                    bus.y_out}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rel", {bus.busy, bus.w_rd_en, bus.w_addr, bus.y_valid,
                    bus.y_out}, 32'd0);

    for (int k = 0; k < 8; k++) begin
      w_mem[k] = 16'h0;
      x_mem[k] = 16'($urandom);
    end
    run_one("zero_w");

    fill(16'h0, 16'h0);
    w_mem[3] = 16'h1000;
    x_mem[3] = 16'h0800;
    run_one("one_tap");

    fill(16'h7FFF, 16'h7FFF);
    run_one("sat_pos");

    fill(16'h7FFF, 16'h8000);
    run_one("sat_neg");

    fill(16'h0, 16'h0);
    w_mem[0] = 16'h0001;
    x_mem[0] = 16'hFFFF;
    run_one("trunc");

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (i % 2 == 0) begin
          w_mem[k] = 16'($urandom);
          x_mem[k] = 16'($urandom);
        end else begin
          w_mem[k] = 16'($urandom_range(0, 4095) - 2048);
          x_mem[k] = 16'($urandom_range(0, 4095) - 2048);
        end
      end
      run_one($sformatf("rnd%0d", i));
    end

    // start held high: re-trigger right after y_valid, period 12
    exp = ref_y();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1;
    wait_valid(lat);
    chk("b2b_lat1", lat, 32'd11);
    chk("b2b_y1", {16'b0, bus.y_out}, {16'b0, exp});
    chk("b2b_busy_v", {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("b2b_busy2", {31'b0, bus.busy}, 32'd1);
    wait_valid(lat);
    chk("b2b_lat2", lat, 32'd11);
    chk("b2b_y2", {16'b0, bus.y_out}, {16'b0, exp});
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.y_valid || bus.busy) seen++;
    end
    chk("b2b_no_third", seen, 32'd0);

    // start re-pulsed at cycle 4, reset dropped at cycle 6
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("abort_zero", {bus.busy, bus.w_rd_en, bus.w_addr, bus.y_valid,
                       bus.y_out}, 32'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.y_valid || bus.busy || bus.w_rd_en) seen++;
    end
    chk("abort_hold", seen, 32'd0);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.y_valid || bus.busy) seen++;
    end
    chk("abort_no_queue", seen, 32'd0);
    for (int k = 0; k < 8; k++) begin
      w_mem[k] = 16'($urandom);
      x_mem[k] = 16'($urandom_range(0, 8191) - 4096);
    end
    run_one("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
